bcd_counter: RTL and testbench

BCD_COUNTER -- requirements
Module: bcd_counter

---
 rtl/bcd_counter_pkg.sv | 44 ++++
 rtl/bcd_counter_digit.sv | 47 ++++
 rtl/bcd_counter.sv | 117 +++++++++++
 tb/tb_bcd_counter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_pkg.sv
// ---------------------------------------------------------------------------
// bcd_counter_pkg
// Shared types and constants for the BCD counter slice.
//   bcd_t         : one 4-bit BCD decade
//   BCD_MAX       : largest legal decade value (9)
//   MAX_DIGITS    : largest supported number of decades
//   action_t      : the single action the counter takes on a clock edge
//   clamp_digit   : forces an out-of-range nibble to 9
//   select_action : resolves clr/load/en into one action (clr wins, then load)
// ---------------------------------------------------------------------------
package bcd_counter_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX    = 4'd9;
   localparam int   MAX_DIGITS = 6;

   typedef enum logic [1:0] {
      ACT_HOLD = 2'd0,
      ACT_STEP = 2'd1,
      ACT_LOAD = 2'd2,
      ACT_CLR  = 2'd3
   } action_t;

   function automatic bcd_t clamp_digit(input bcd_t d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

   function automatic action_t select_action(input logic clr,
                                             input logic load,
                                             input logic en);
      action_t a;
      a = ACT_HOLD;
      if (clr) begin
         a = ACT_CLR;
      end else if (load) begin
         a = ACT_LOAD;
      end else if (en) begin
         a = ACT_STEP;
      end
      return a;
   endfunction

endpackage

// File: rtl/bcd_counter_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
// One combinational BCD decade stage. When cin is high the digit steps by one
// in the selected direction; cout reports a carry (9 -> 0 going up) or a
// borrow (0 -> 9 going down) into the next decade.
// Ports:
//   digit      in  current decade value
//   up         in  1 = increment, 0 = decrement
//   cin        in  step request / carry-borrow from the lower decade
//   next_digit out decade value after the step
//   cout       out carry or borrow into the next decade
// ---------------------------------------------------------------------------
module bcd_digit
   import bcd_counter_pkg::*;
(
   input  bcd_t digit,
   input  logic up,
   input  logic cin,
   output bcd_t next_digit,
   output logic cout
);

   // A nibble above 9 can never be stored, but it is still treated as 9 so the
   // stage always produces a legal decade value.
   always_comb begin
      next_digit = digit;
      cout       = 1'b0;
      if (cin) begin
         if (up) begin
            if (digit >= BCD_MAX) begin
               next_digit = '0;
               cout       = 1'b1;
            end else begin
               next_digit = digit + 4'd1;
            end
         end else begin
            if (digit == '0) begin
               next_digit = BCD_MAX;
               cout       = 1'b1;
            end else begin
               next_digit = clamp_digit(digit) - 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/bcd_counter.sv
// ---------------------------------------------------------------------------
// bcd_counter
// Multi-decade up/down BCD counter with synchronous clear and load,
// optional saturation at the limits, a terminal-count pulse and a sticky
// overflow/underflow flag.
// Parameters:
//   N_DIGITS  number of BCD decades (1..6)
//   SATURATE  0 = wrap at the limits, 1 = hold at the limits
// Ports:
//   clk       in  rising-edge clock
//   reset_n   in  asynchronous active-low reset
//   en        in  count enable, one step per edge
//   up        in  1 = increment, 0 = decrement
//   clr       in  synchronous clear (highest priority)
//   load      in  synchronous parallel load
//   load_val  in  BCD load value, digit 0 in bits [3:0]
//   count     out registered BCD count, digit 0 in bits [3:0]
//   tc        out registered terminal-count pulse (one cycle on wrap)
//   ovf       out sticky overflow/underflow flag
// ---------------------------------------------------------------------------
module bcd_counter
   import bcd_counter_pkg::*;
#(
   parameter int N_DIGITS = 4,
   parameter bit SATURATE = 1'b0
)
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  en,
   input  logic                  up,
   input  logic                  clr,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] load_val,
   output logic [4*N_DIGITS-1:0] count,
   output logic                  tc,
   output logic                  ovf
);

   localparam int W = 4 * N_DIGITS;

   if (N_DIGITS < 1 || N_DIGITS > MAX_DIGITS) begin : g_bad_n_digits
      $error("bcd_counter: N_DIGITS must be in 1..%0d", MAX_DIGITS);
   end

   logic [N_DIGITS:0] carry;
   logic [W-1:0]      stepped;
   logic [W-1:0]      clamped_load;
   logic [W-1:0]      count_next;
   logic              tc_next;
   logic              ovf_next;
   action_t           action;

   // The lowest decade always receives a step request; a carry out of the top
   // decade therefore means every decade sat at its limit, i.e. the step
   // crosses all-9s (up) or all-0s (down).
   assign carry[0] = 1'b1;

   for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .digit      (count[4*g +: 4]),
         .up         (up),
         .cin        (carry[g]),
         .next_digit (stepped[4*g +: 4]),
         .cout       (carry[g+1])
      );

      assign clamped_load[4*g +: 4] = clamp_digit(load_val[4*g +: 4]);
   end

   assign action = select_action(clr, load, en);

   // Next-state selection. On a limit crossing the stepped value is already
   // the wrapped value, so wrapping just accepts it; saturation keeps count.
   always_comb begin
      count_next = count;
      ovf_next   = ovf;
      tc_next    = 1'b0;
      case (action)
         ACT_CLR: begin
            count_next = '0;
            ovf_next   = 1'b0;
         end
         ACT_LOAD: begin
            count_next = clamped_load;
            ovf_next   = 1'b0;
         end
         ACT_STEP: begin
            if (carry[N_DIGITS]) begin
               ovf_next = 1'b1;
               if (!SATURATE) begin
                  count_next = stepped;
                  tc_next    = 1'b1;
               end
            end else begin
               count_next = stepped;
            end
         end
         default: begin
         end
      endcase
   end

   // State registers; reset aborts any step in progress.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         tc    <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         count <= count_next;
         tc    <= tc_next;
         ovf   <= ovf_next;
      end
   end

endmodule

// File: tb/tb_bcd_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_counter
// Self-checking bench for bcd_counter. Three instances share the control
// inputs: a 2-decade wrapping counter, a 2-decade saturating counter and a
// 4-decade wrapping counter. A decimal-integer model tracks all three.
// ---------------------------------------------------------------------------
module tb_bcd_counter;

   logic        clk;
   logic        reset_n;
   logic        en;
   logic        up;
   logic        clr;
   logic        load;
   logic [15:0] lv;

   logic [7:0]  count_a;
   logic [7:0]  count_s;
   logic [15:0] count_w;
   logic        tc_a, tc_s, tc_w;
   logic        ovf_a, ovf_s, ovf_w;

   logic [23:0] dcount [3];
   logic [2:0]  dtc;
   logic [2:0]  dovf;

   int checks   = 0;
   int failures = 0;

   int mval [3];
   bit mtc  [3];
   bit movf [3];

   bcd_counter #(.N_DIGITS(2), .SATURATE(1'b0)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(lv[7:0]), .count(count_a), .tc(tc_a), .ovf(ovf_a)
   );

   bcd_counter #(.N_DIGITS(2), .SATURATE(1'b1)) u_dut_s (
      .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(lv[7:0]), .count(count_s), .tc(tc_s), .ovf(ovf_s)
   );

   bcd_counter #(.N_DIGITS(4), .SATURATE(1'b0)) u_dut_w (
      .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(lv), .count(count_w), .tc(tc_w), .ovf(ovf_w)
   );

   assign dcount[0] = {16'd0, count_a};
   assign dcount[1] = {16'd0, count_s};
   assign dcount[2] = {8'd0, count_w};
   assign dtc       = {tc_w, tc_s, tc_a};
   assign dovf      = {ovf_w, ovf_s, ovf_a};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model configuration per instance index.
   function automatic int ndig(input int i);
      return (i == 2) ? 4 : 2;
   endfunction

   function automatic bit msat(input int i);
      return (i == 1);
   endfunction

   function automatic int limit(input int nd);
      int l;
      l = 1;
      for (int k = 0; k < nd; k++) l = l * 10;
      return l - 1;
   endfunction

   function automatic logic [23:0] to_bcd(input int v);
      logic [23:0] r;
      int t;
      r = '0;
      t = v;
      for (int d = 0; d < 6; d++) begin
         r[4*d +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int load_value(input logic [15:0] val, input int nd);
      int v;
      int nib;
      v = 0;
      for (int d = nd - 1; d >= 0; d--) begin
         nib = int'(val[4*d +: 4]);
         if (nib > 9) nib = 9;
         v = v * 10 + nib;
      end
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mval[i] = 0;
         mtc[i]  = 1'b0;
         movf[i] = 1'b0;
      end
   endtask

   // Behaviour of one clock edge on a plain decimal value.
   task automatic model_edge();
      int lim;
      if (!reset_n) begin
         model_reset();
      end else begin
         for (int i = 0; i < 3; i++) begin
            lim    = limit(ndig(i));
            mtc[i] = 1'b0;
            if (clr) begin
               mval[i] = 0;
               movf[i] = 1'b0;
            end else if (load) begin
               mval[i] = load_value(lv, ndig(i));
               movf[i] = 1'b0;
            end else if (en) begin
               if (up && mval[i] == lim) begin
                  movf[i] = 1'b1;
                  if (!msat(i)) begin
                     mval[i] = 0;
                     mtc[i]  = 1'b1;
                  end
               end else if (!up && mval[i] == 0) begin
                  movf[i] = 1'b1;
                  if (!msat(i)) begin
                     mval[i] = lim;
                     mtc[i]  = 1'b1;
                  end
               end else if (up) begin
                  mval[i] = mval[i] + 1;
               end else begin
                  mval[i] = mval[i] - 1;
               end
            end
         end
      end
   endtask

   // Inputs change just after a falling edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; lv = '0;
      model_reset();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (dcount[i] !== 24'h0) begin
            failures++;
            $display("[TB] FAIL reset_count[%0d]: got %h expected 000000", i, dcount[i]);
         end
         checks++;
         if (dtc[i] !== 1'b0 || dovf[i] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags[%0d]: got tc=%b ovf=%b expected 0 0", i, dtc[i], dovf[i]);
         end
      end
      reset_n = 1'b1;
   endtask

   task automatic test_count_up();
      int tc_seen;
      tc_seen = 0;
      en = 1'b1; up = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (tc_a !== 1'b0) tc_seen++;
      end
      checks++;
      if (count_a !== 8'h10) begin
         failures++;
         $display("[TB] FAIL count_up_value: got %h expected 10", count_a);
      end
      checks++;
      if (tc_seen != 0) begin
         failures++;
         $display("[TB] FAIL count_up_tc: got %0d tc cycles expected 0", tc_seen);
      end
      en = 1'b0;
   endtask

   task automatic test_wrap_up();
      lv = 16'h0098; load = 1'b1;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1;
      tick();
      checks++;
      if (count_a !== 8'h99 || tc_a !== 1'b0) begin
         failures++;
         $display("[TB] FAIL wrap_up_pre: got %h tc=%b expected 99 tc=0", count_a, tc_a);
      end
      tick();
      checks++;
      if (count_a !== 8'h00 || tc_a !== 1'b1 || ovf_a !== 1'b1) begin
         failures++;
         $display("[TB] FAIL wrap_up: got %h tc=%b ovf=%b expected 00 tc=1 ovf=1", count_a, tc_a, ovf_a);
      end
      en = 1'b0;
      tick();
      checks++;
      if (count_a !== 8'h00 || tc_a !== 1'b0 || ovf_a !== 1'b1) begin
         failures++;
         $display("[TB] FAIL wrap_up_hold: got %h tc=%b ovf=%b expected 00 tc=0 ovf=1", count_a, tc_a, ovf_a);
      end
   endtask

   task automatic test_wrap_down();
      clr = 1'b1;
      tick();
      clr = 1'b0; en = 1'b1; up = 1'b0;
      tick();
      checks++;
      if (count_a !== 8'h99 || tc_a !== 1'b1 || ovf_a !== 1'b1) begin
         failures++;
         $display("[TB] FAIL wrap_down: got %h tc=%b ovf=%b expected 99 tc=1 ovf=1", count_a, tc_a, ovf_a);
      end
      en = 1'b0; clr = 1'b1;
      tick();
      checks++;
      if (count_a !== 8'h00 || ovf_a !== 1'b0 || tc_a !== 1'b0) begin
         failures++;
         $display("[TB] FAIL clear_after_wrap: got %h tc=%b ovf=%b expected 00 tc=0 ovf=0", count_a, tc_a, ovf_a);
      end
      clr = 1'b0;
   endtask

   task automatic test_saturate();
      lv = 16'h0099; load = 1'b1;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (count_s !== 8'h99 || tc_s !== 1'b0 || ovf_s !== 1'b1) begin
            failures++;
            $display("[TB] FAIL saturate_%0d: got %h tc=%b ovf=%b expected 99 tc=0 ovf=1", k, count_s, tc_s, ovf_s);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_load_priority();
      lv = 16'h00AF; load = 1'b1; en = 1'b1; up = 1'b1;
      tick();
      checks++;
      if (count_a !== 8'h99 || ovf_a !== 1'b0 || tc_a !== 1'b0) begin
         failures++;
         $display("[TB] FAIL load_clamp: got %h tc=%b ovf=%b expected 99 tc=0 ovf=0", count_a, tc_a, ovf_a);
      end
      checks++;
      if (count_w !== 16'h0099) begin
         failures++;
         $display("[TB] FAIL load_clamp_wide: got %h expected 0099", count_w);
      end
      clr = 1'b1;
      tick();
      checks++;
      if (count_a !== 8'h00 || count_w !== 16'h0000) begin
         failures++;
         $display("[TB] FAIL clr_priority: got %h/%h expected 00/0000", count_a, count_w);
      end
      clr = 1'b0; load = 1'b0; en = 1'b0;
   endtask

   task automatic test_reset_mid();
      lv = 16'h1234; load = 1'b1;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1;
      tick();
      checks++;
      if (count_w !== 16'h1235) begin
         failures++;
         $display("[TB] FAIL pre_reset_count: got %h expected 1235", count_w);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (count_w !== 16'h0000 || tc_w !== 1'b0 || ovf_w !== 1'b0) begin
         failures++;
         $display("[TB] FAIL async_reset: got %h tc=%b ovf=%b expected 0000 tc=0 ovf=0", count_w, tc_w, ovf_w);
      end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      checks++;
      if (count_w !== 16'h0001 || count_a !== 8'h01) begin
         failures++;
         $display("[TB] FAIL resume_after_reset: got %h/%h expected 0001/01", count_w, count_a);
      end
      en = 1'b0;
   endtask

   task automatic test_random();
      int r;
      int sel;
      for (int k = 0; k < 600; k++) begin
         r    = $urandom_range(0, 15);
         clr  = (r == 0);
         load = (r == 1 || r == 2);
         en   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) up = ~up;
         sel = $urandom_range(0, 3);
         case (sel)
            0:       lv = 16'($urandom);
            1:       lv = 16'h9999;
            2:       lv = 16'h0000;
            default: lv = 16'h9990 | 16'($urandom_range(5, 9));
         endcase
         tick();
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (dcount[i] !== to_bcd(mval[i]) || dtc[i] !== mtc[i] || dovf[i] !== movf[i]) begin
               failures++;
               $display("[TB] FAIL random[%0d] dut%0d: got %h tc=%b ovf=%b expected %h tc=%b ovf=%b",
                        k, i, dcount[i], dtc[i], dovf[i], to_bcd(mval[i]), mtc[i], movf[i]);
            end
         end
      end
      en = 1'b0; clr = 1'b0; load = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_wrap_up();
      test_wrap_down();
      test_saturate();
      test_load_priority();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
